bfp_krnl_sched: RTL

Tile sequencer for the BFP convolution kernel (`bfp_krnl`). It gates the upstream pixel/coefficient beats into the kernel and counts channel-group beats per output pixel, output pixels per filter and filters per tile. From these counts it generates `acc_result_vld`, `filter_finish_data`, the per-filter bias load and `shift_bits`. It tracks filters still in flight through the kernel pipeline using `filter_finish_cal`, and reports tile completion to the layer controller.

---
 rtl/bfp_pkg.sv | 25 ++
 rtl/bfp_krnl_sched_if.sv | 50 +++++
 rtl/bfp_sched_cnt.sv | 42 ++++
 rtl/bfp_krnl_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bfp_pkg.sv
// ---------------------------------------------------------------------------
// Module   : bfp_pkg
// Purpose  : Shared types and constants for the BFP kernel tile sequencer.
//            Holds the scheduler state encoding, the default counter width
//            and the BFP shift width.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package bfp_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int SHIFT_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BIAS  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/bfp_krnl_sched_if.sv
// ---------------------------------------------------------------------------
// Module   : bfp_krnl_sched_if
// Purpose  : Handshake bundle between the tile sequencer, the upstream beat
//            source, the bias stream and the convolution kernel.
// Ports    : master = sequencer view, slave = environment/kernel view.
//            src_vld/src_rdy          upstream beat handshake
//            krnl_up_vld/krnl_up_rdy  beat handshake into the kernel
//            acc_result_vld           last channel-group beat of a pixel
//            filter_finish_data/_cal  filter issued / filter computed
//            bias_in_vld/rdy/dat      bias stream
//            bias_vld/bias_dat        bias load to the kernel
//            shift_bits               BFP shift to the kernel
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface bfp_krnl_sched_if
    import bfp_pkg::*;
#(
    parameter int BIAS_W = 32
);
    logic               src_vld;
    logic               src_rdy;
    logic               krnl_up_vld;
    logic               krnl_up_rdy;
    logic               acc_result_vld;
    logic               filter_finish_data;
    logic               filter_finish_cal;
    logic               bias_in_vld;
    logic               bias_in_rdy;
    logic [BIAS_W-1:0]  bias_in_dat;
    logic               bias_vld;
    logic [BIAS_W-1:0]  bias_dat;
    logic [SHIFT_W-1:0] shift_bits;

    modport master (
        input  src_vld, krnl_up_rdy, filter_finish_cal, bias_in_vld, bias_in_dat,
        output src_rdy, krnl_up_vld, acc_result_vld, filter_finish_data,
               bias_in_rdy, bias_vld, bias_dat, shift_bits
    );

    modport slave (
        output src_vld, krnl_up_rdy, filter_finish_cal, bias_in_vld, bias_in_dat,
        input  src_rdy, krnl_up_vld, acc_result_vld, filter_finish_data,
               bias_in_rdy, bias_vld, bias_dat, shift_bits
    );

endinterface

`default_nettype wire

// File: rtl/bfp_sched_cnt.sv
// ---------------------------------------------------------------------------
// Module   : bfp_sched_cnt
// Purpose  : CNT_W wrap counter. Counts 0..limit, returning to 0 on the
//            increment taken while at limit.
// Ports    : clk, rst   clock / synchronous active-high reset
//            inc        advance request
//            clr        synchronous clear (wins over inc)
//            limit      terminal value (count - 1)
//            last       value == limit
//            wrap       increment taken at limit
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module bfp_sched_cnt #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc,
    input  wire logic             clr,
    input  wire logic [CNT_W-1:0] limit,
    output logic                  last,
    output logic                  wrap
);

    logic [CNT_W-1:0] value;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (inc) begin
            value <= last ? '0 : value + 1'b1;
        end
    end

    assign last = (value == limit);
    assign wrap = inc & last;

endmodule

`default_nettype wire

// File: rtl/bfp_krnl_sched.sv
// ---------------------------------------------------------------------------
// Module   : bfp_krnl_sched
// Purpose  : Tile sequencer for the BFP convolution kernel. Gates upstream
//            beats into the kernel, counts channel-group beats / pixels /
//            filters, loads one bias per filter, limits filters in flight
//            and reports tile completion.
// Ports    : clk, rst             clock / synchronous active-high reset
//            start, cfg_*         tile start and tile configuration
//            busy, done           status to the layer controller
//            bus (master)         beat, bias and kernel handshakes
// Options  : BFP_SCHED_PERF_EN adds saturating 32-bit counters perf_beats,
//            perf_stall_src, perf_stall_krnl, perf_stall_credit as outputs.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module bfp_krnl_sched
    import bfp_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MAX_OUT = 2,
    parameter int BIAS_W  = 32
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               start,
    input  wire logic [CNT_W-1:0]   cfg_ncg,
    input  wire logic [CNT_W-1:0]   cfg_npix,
    input  wire logic [CNT_W-1:0]   cfg_nfilt,
    input  wire logic [SHIFT_W-1:0] cfg_shift,
    output logic                    busy,
    output logic                    done,
`ifdef BFP_SCHED_PERF_EN
    output logic [31:0]             perf_beats,
    output logic [31:0]             perf_stall_src,
    output logic [31:0]             perf_stall_krnl,
    output logic [31:0]             perf_stall_credit,
`endif
    bfp_krnl_sched_if.master        bus
);

    localparam int              OUT_W   = 3;
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);

    sched_state_t       state;
    sched_state_t       state_nxt;
    logic [CNT_W-1:0]   lim_ncg;
    logic [CNT_W-1:0]   lim_npix;
    logic [CNT_W-1:0]   lim_nfilt;
    logic [OUT_W-1:0]   outs;
    logic [BIAS_W-1:0]  bias_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               bias_vld_q;
    logic               ffd_q;

    logic in_run, go, cfg_zero, credit_ok, bias_hs, fire;
    logic cg_last, cg_wrap, pix_last, pix_wrap, filt_last, filt_wrap;
    logic out_inc, out_dec;
    logic unused_lasts;

    assign in_run    = (state == ST_RUN);
    assign go        = (state == ST_IDLE) & start;
    assign cfg_zero  = (cfg_ncg == '0) | (cfg_npix == '0) | (cfg_nfilt == '0);
    assign credit_ok = (outs != OUT_MAX);
    assign bias_hs   = (state == ST_BIAS) & credit_ok & bus.bias_in_vld;
    assign fire      = in_run & bus.src_vld & bus.krnl_up_rdy;

    // pix_wrap marks the last beat of a filter; filt_wrap the last beat of the tile.
    assign out_inc = pix_wrap;
    // A completion report with nothing in flight is dropped.
    assign out_dec = bus.filter_finish_cal & (outs != '0);

    // The pixel/filter "last" flags only feed their own counters' wrap.
    assign unused_lasts = pix_last ^ filt_last;

    bfp_sched_cnt #(.CNT_W(CNT_W)) u_cg (
        .clk(clk), .rst(rst), .inc(fire), .clr(go), .limit(lim_ncg),
        .last(cg_last), .wrap(cg_wrap)
    );

    bfp_sched_cnt #(.CNT_W(CNT_W)) u_pix (
        .clk(clk), .rst(rst), .inc(cg_wrap), .clr(go), .limit(lim_npix),
        .last(pix_last), .wrap(pix_wrap)
    );

    bfp_sched_cnt #(.CNT_W(CNT_W)) u_filt (
        .clk(clk), .rst(rst), .inc(pix_wrap), .clr(go), .limit(lim_nfilt),
        .last(filt_last), .wrap(filt_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = cfg_zero ? ST_DONE : ST_BIAS;
            ST_BIAS:  if (bias_hs) state_nxt = ST_RUN;
            ST_RUN: begin
                if (filt_wrap)     state_nxt = ST_DRAIN;
                else if (pix_wrap) state_nxt = ST_BIAS;
            end
            // Increments are applied on the firing edge, so none is pending here.
            ST_DRAIN: if (outs == '0) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lim_ncg    <= '0;
            lim_npix   <= '0;
            lim_nfilt  <= '0;
            shift_q    <= '0;
            bias_q     <= '0;
            bias_vld_q <= 1'b0;
            ffd_q      <= 1'b0;
            outs       <= '0;
        end else begin
            bias_vld_q <= bias_hs;
            ffd_q      <= out_inc;
            if (bias_hs) begin
                bias_q <= bus.bias_in_dat;
            end
            if (go) begin
                lim_ncg   <= cfg_ncg - 1'b1;
                lim_npix  <= cfg_npix - 1'b1;
                lim_nfilt <= cfg_nfilt - 1'b1;
                shift_q   <= cfg_shift;
            end
            unique case ({out_inc, out_dec})
                2'b10:   outs <= outs + 1'b1;
                2'b01:   outs <= outs - 1'b1;
                default: outs <= outs;
            endcase
        end
    end

    assign busy                   = (state != ST_IDLE);
    assign done                   = (state == ST_DONE);
    assign bus.krnl_up_vld        = in_run & bus.src_vld;
    assign bus.src_rdy            = in_run & bus.krnl_up_rdy;
    assign bus.acc_result_vld     = in_run & cg_last;
    assign bus.bias_in_rdy        = (state == ST_BIAS) & credit_ok;
    assign bus.bias_vld           = bias_vld_q;
    assign bus.bias_dat           = bias_q;
    assign bus.filter_finish_data = ffd_q;
    assign bus.shift_bits         = shift_q;

`ifdef BFP_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || go) begin
            perf_beats        <= '0;
            perf_stall_src    <= '0;
            perf_stall_krnl   <= '0;
            perf_stall_credit <= '0;
        end else begin
            if (fire && perf_beats != '1)
                perf_beats <= perf_beats + 1'b1;
            if (in_run && !bus.src_vld && perf_stall_src != '1)
                perf_stall_src <= perf_stall_src + 1'b1;
            if (in_run && bus.src_vld && !bus.krnl_up_rdy && perf_stall_krnl != '1)
                perf_stall_krnl <= perf_stall_krnl + 1'b1;
            if (state == ST_BIAS && !credit_ok && perf_stall_credit != '1)
                perf_stall_credit <= perf_stall_credit + 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire
